// File: rtl/ysyx_22040895_mdu_if.sv
// Request/response bundle between the EXU issue logic and the multiply/divide unit.
// The master drives a request plus flush; the slave answers with ready, a completion pulse and the result.
interface ysyx_22040895_mdu_if #(
    parameter int XLEN = 64
);
    logic            valid_i_mdu;
    logic [3:0]      mduop_i_mdu;
    logic [XLEN-1:0] src1_i_mdu;
    logic [XLEN-1:0] src2_i_mdu;
    logic            flush_i_mdu;
    logic            ready_o_mdu;
    logic            out_valid_o_mdu;
    logic [XLEN-1:0] result_o_mdu;

    modport master (
        output valid_i_mdu,
        output mduop_i_mdu,
        output src1_i_mdu,
        output src2_i_mdu,
        output flush_i_mdu,
        input  ready_o_mdu,
        input  out_valid_o_mdu,
        input  result_o_mdu
    );

    modport slave (
        input  valid_i_mdu,
        input  mduop_i_mdu,
        input  src1_i_mdu,
        input  src2_i_mdu,
        input  flush_i_mdu,
        output ready_o_mdu,
        output out_valid_o_mdu,
        output result_o_mdu
    );
endinterface

// File: rtl/ysyx_22040895_mdu.sv
// Multi-cycle RV64M multiply/divide unit: radix-2 shift-add multiplier (mul/mulw) and
// 32-step restoring divider (divw/remw), fixed latency, one-cycle completion pulse.
module ysyx_22040895_mdu #(
    parameter int XLEN = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    ysyx_22040895_mdu_if.slave    mdu
);
    localparam int WPAD = XLEN - 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_reg;
    logic [6:0]      count_reg;
    logic            ready_reg;
    logic            out_valid_reg;
    logic [XLEN-1:0] result_reg;

    logic            is_word_reg;
    logic            is_rem_reg;
    logic [XLEN-1:0] mcand_reg;
    logic [XLEN-1:0] mplier_reg;
    logic [XLEN-1:0] acc_reg;

    logic [31:0]     quot_reg;
    logic [31:0]     rem_reg;
    logic [31:0]     divisor_reg;
    logic [31:0]     dividend_reg;
    logic            neg_q_reg;
    logic            neg_r_reg;
    logic            div_zero_reg;
    logic            div_ovf_reg;

    logic            op_ok;
    logic [31:0]     src1_w;
    logic [31:0]     src2_w;
    logic [31:0]     src1_mag;
    logic [31:0]     src2_mag;
    logic [XLEN-1:0] acc_next;
    logic [32:0]     div_shift;
    logic            div_ge;
    logic [31:0]     div_sub;
    logic [31:0]     rem_next;
    logic [31:0]     quot_next;
    logic [31:0]     q_signed;
    logic [31:0]     r_signed;
    logic [XLEN-1:0] mul_result;
    logic [XLEN-1:0] div_result;
    logic [XLEN-1:0] final_result;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{WPAD{v[31]}}, v};
    endfunction

    always_comb begin
        op_ok = 1'b0;
        case (mdu.mduop_i_mdu)
            4'b0001, 4'b0101, 4'b1001, 4'b1101: op_ok = 1'b1;
            default:                            op_ok = 1'b0;
        endcase
    end

    assign src1_w   = mdu.src1_i_mdu[31:0];
    assign src2_w   = mdu.src2_i_mdu[31:0];
    assign src1_mag = src1_w[31] ? (32'd0 - src1_w) : src1_w;
    assign src2_mag = src2_w[31] ? (32'd0 - src2_w) : src2_w;

    // One multiplier bit per cycle; the final step is folded into the completion edge.
    assign acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

    // Restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
    // When the subtraction succeeds the true difference is below the divisor, so 32 bits suffice.
    assign div_shift = {rem_reg, quot_reg[31]};
    assign div_ge    = div_shift >= {1'b0, divisor_reg};
    assign div_sub   = div_shift[31:0] - divisor_reg;
    assign rem_next  = div_ge ? div_sub : div_shift[31:0];
    assign quot_next = {quot_reg[30:0], div_ge};

    assign q_signed  = neg_q_reg ? (32'd0 - quot_next) : quot_next;
    assign r_signed  = neg_r_reg ? (32'd0 - rem_next)  : rem_next;

    assign mul_result = is_word_reg ? sext32(acc_next[31:0]) : acc_next;

    always_comb begin
        div_result = '0;
        if (div_zero_reg) begin
            div_result = is_rem_reg ? sext32(dividend_reg) : '1;
        end else if (div_ovf_reg) begin
            div_result = is_rem_reg ? '0 : sext32(32'h8000_0000);
        end else begin
            div_result = is_rem_reg ? sext32(r_signed) : sext32(q_signed);
        end
    end

    assign final_result = (state_reg == DIV) ? div_result : mul_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            count_reg     <= 7'd0;
            ready_reg     <= 1'b1;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            is_word_reg   <= 1'b0;
            is_rem_reg    <= 1'b0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            acc_reg       <= '0;
            quot_reg      <= 32'd0;
            rem_reg       <= 32'd0;
            divisor_reg   <= 32'd0;
            dividend_reg  <= 32'd0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
            div_zero_reg  <= 1'b0;
            div_ovf_reg   <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // A flush in IDLE blocks a simultaneous request.
                    if (mdu.valid_i_mdu && op_ok && !mdu.flush_i_mdu) begin
                        ready_reg    <= 1'b0;
                        is_word_reg  <= mdu.mduop_i_mdu[2] | mdu.mduop_i_mdu[3];
                        is_rem_reg   <= mdu.mduop_i_mdu[3] & mdu.mduop_i_mdu[2];
                        acc_reg      <= '0;
                        rem_reg      <= 32'd0;
                        quot_reg     <= src1_mag;
                        divisor_reg  <= src2_mag;
                        dividend_reg <= src1_w;
                        neg_q_reg    <= src1_w[31] ^ src2_w[31];
                        neg_r_reg    <= src1_w[31];
                        div_zero_reg <= (src2_w == 32'd0);
                        div_ovf_reg  <= (src1_w == 32'h8000_0000) && (src2_w == 32'hFFFF_FFFF);
                        if (mdu.mduop_i_mdu[2]) begin
                            mcand_reg  <= {{WPAD{1'b0}}, src1_w};
                            mplier_reg <= {{WPAD{1'b0}}, src2_w};
                        end else begin
                            mcand_reg  <= mdu.src1_i_mdu;
                            mplier_reg <= mdu.src2_i_mdu;
                        end
                        if (mdu.mduop_i_mdu[3]) begin
                            state_reg <= DIV;
                            count_reg <= 7'd31;
                        end else begin
                            state_reg <= MUL;
                            count_reg <= mdu.mduop_i_mdu[2] ? 7'd31 : 7'd63;
                        end
                    end
                end
                MUL, DIV: begin
                    if (mdu.flush_i_mdu) begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b1;
                        count_reg <= 7'd0;
                    end else begin
                        acc_reg    <= acc_next;
                        mcand_reg  <= mcand_reg << 1;
                        mplier_reg <= mplier_reg >> 1;
                        rem_reg    <= rem_next;
                        quot_reg   <= quot_next;
                        if (count_reg == 7'd0) begin
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                            result_reg    <= final_result;
                        end else begin
                            count_reg <= count_reg - 7'd1;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign mdu.ready_o_mdu     = ready_reg;
    assign mdu.out_valid_o_mdu = out_valid_reg;
    assign mdu.result_o_mdu    = result_reg;
endmodule

// File: tb/tb_ysyx_22040895_mdu.sv
// Directed scoreboard bench for the multiply/divide unit: stimulus pushes expected results
// with their due cycle, a negedge monitor pops and compares on every completion pulse.
module tb_ysyx_22040895_mdu;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ysyx_22040895_mdu_if #(.XLEN(64)) bus ();

    ysyx_22040895_mdu #(.XLEN(64)) dut (
        .clk (clk),
        .rst (rst),
        .mdu (bus.slave)
    );

    typedef struct {
        logic [63:0] res;
        int          due;
        string       name;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] s1;
        logic [63:0] s2;
        logic [63:0] res;
        int          n;
        string       name;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] hold     = 64'd0;
    exp_t        mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every completion must match the oldest expectation, at its due cycle.
    always @(negedge clk) begin
        if (rst) begin
            hold = 64'd0;
        end else if (bus.out_valid_o_mdu) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected out_valid: result %h at cycle %0d", bus.result_o_mdu, cyc);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, " result"}, bus.result_o_mdu, mon_e.res);
                check({mon_e.name, " cycle"}, 64'(cyc), 64'(mon_e.due));
                $display("cycle %0d: %s -> %h", cyc, mon_e.name, bus.result_o_mdu);
                hold = mon_e.res;
            end
        end else begin
            check("result hold", bus.result_o_mdu, hold);
        end
    end

    // Called right after a negedge; drives the request for one cycle and returns its cycle T.
    task automatic issue(input logic [3:0] op, input logic [63:0] s1, input logic [63:0] s2,
                         input logic expect_it, input logic [63:0] res, input int n,
                         input string name, output int t);
        exp_t e;
        bus.valid_i_mdu = 1'b1;
        bus.mduop_i_mdu = op;
        bus.src1_i_mdu  = s1;
        bus.src2_i_mdu  = s2;
        t = cyc;
        if (expect_it) begin
            e.res  = res;
            e.due  = cyc + n + 1;
            e.name = name;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.valid_i_mdu = 1'b0;
        bus.mduop_i_mdu = 4'b0000;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!bus.ready_o_mdu && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("ready within bound", 64'(bus.ready_o_mdu), 64'd1);
    endtask

    task automatic wait_drain();
        int k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("scoreboard drained", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic add_vec(input logic [3:0] op, input logic [63:0] s1, input logic [63:0] s2,
                           input logic [63:0] res, input int n, input string name);
        vec_t v;
        v.op = op; v.s1 = s1; v.s2 = s2; v.res = res; v.n = n; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst                 = 1'b1;
        bus.valid_i_mdu     = 1'b0;
        bus.mduop_i_mdu     = 4'b0000;
        bus.src1_i_mdu      = 64'd0;
        bus.src2_i_mdu      = 64'd0;
        bus.flush_i_mdu     = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset ready", 64'(bus.ready_o_mdu), 64'd1);
        check("reset out_valid", 64'(bus.out_valid_o_mdu), 64'd0);
        check("reset result", bus.result_o_mdu, 64'd0);

        // mul with the ready profile around completion.
        issue(4'b0001, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 64, "mul 3*-5", t);
        check("mul ready T+1", 64'(bus.ready_o_mdu), 64'd0);
        wait_until(t + 65);
        check("mul ready T+65", 64'(bus.ready_o_mdu), 64'd0);
        check("mul out_valid T+65", 64'(bus.out_valid_o_mdu), 64'd1);
        wait_until(t + 66);
        check("mul ready T+66", 64'(bus.ready_o_mdu), 64'd1);

        add_vec(4'b0101, 64'hDEAD_BEEF_4000_0000, 64'hDEAD_BEEF_0000_0002, 64'hFFFF_FFFF_8000_0000, 32, "mulw hi-garbage");
        add_vec(4'b1001, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 32, "divw -7/2");
        add_vec(4'b1101, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 32, "remw -7%2");
        add_vec(4'b1001, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32, "divw 5/0");
        add_vec(4'b1101, 64'd5, 64'd0, 64'd5, 32, "remw 5%0");
        add_vec(4'b1001, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 32, "divw ovf");
        add_vec(4'b1101, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 32, "remw ovf");
        add_vec(4'b0001, 64'h0000_0001_0000_0001, 64'h0000_0001_0000_0003, 64'h0000_0004_0000_0003, 64, "mul wide");
        add_vec(4'b1001, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 32, "divw 100/-7");
        add_vec(4'b1101, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 32, "remw 100%-7");
        add_vec(4'b0101, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 64'd1, 32, "mulw -1*-1");

        foreach (vecs[i]) begin
            wait_ready();
            issue(vecs[i].op, vecs[i].s1, vecs[i].s2, 1'b1, vecs[i].res, vecs[i].n, vecs[i].name, t);
        end
        wait_drain();

        // A second request while busy must be dropped.
        wait_ready();
        issue(4'b0001, 64'd7, 64'd6, 1'b1, 64'd42, 64, "mul 7*6", t);
        wait_until(t + 3);
        issue(4'b1001, 64'd9, 64'd3, 1'b0, 64'd0, 32, "divw busy", t);
        check("busy ready low", 64'(bus.ready_o_mdu), 64'd0);
        wait_drain();

        // Non-op codes and a flush in IDLE must not start anything.
        wait_ready();
        issue(4'b0000, 64'd1, 64'd1, 1'b0, 64'd0, 32, "nop 0000", t);
        check("nop 0000 ready", 64'(bus.ready_o_mdu), 64'd1);
        issue(4'b1111, 64'd1, 64'd1, 1'b0, 64'd0, 32, "nop 1111", t);
        check("nop 1111 ready", 64'(bus.ready_o_mdu), 64'd1);
        bus.flush_i_mdu = 1'b1;
        issue(4'b0001, 64'd2, 64'd2, 1'b0, 64'd0, 64, "mul under idle flush", t);
        bus.flush_i_mdu = 1'b0;
        check("idle flush ready", 64'(bus.ready_o_mdu), 64'd1);
        repeat (70) @(negedge clk);

        // Flush mid-mul at T+10, then an immediate new accept at T+11.
        issue(4'b0001, 64'd11, 64'd13, 1'b0, 64'd0, 64, "mul flushed", t);
        wait_until(t + 10);
        bus.flush_i_mdu = 1'b1;
        @(negedge clk);
        bus.flush_i_mdu = 1'b0;
        check("flush back to idle cycle", 64'(cyc), 64'(t + 11));
        check("flush ready", 64'(bus.ready_o_mdu), 64'd1);
        issue(4'b0101, 64'h0000_0000_4000_0000, 64'd2, 1'b1, 64'hFFFF_FFFF_8000_0000, 32, "mulw after flush", t);
        wait_drain();

        // Reset in the middle of a divw discards it.
        wait_ready();
        issue(4'b1001, 64'd100, 64'd7, 1'b0, 64'd0, 32, "divw reset", t);
        wait_until(t + 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid reset ready", 64'(bus.ready_o_mdu), 64'd1);
        check("mid reset out_valid", 64'(bus.out_valid_o_mdu), 64'd0);
        check("mid reset result", bus.result_o_mdu, 64'd0);
        repeat (40) @(negedge clk);
        issue(4'b0001, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 64, "mul after reset", t);
        wait_drain();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
